jtag_host_drv: RTL

- JTAG initiator (host/driver) that drives the TAP pins tck/tms/tdi and samples tdo. It is the opposite end of the core's JTAG OCD/programmer TAP.
- Intended uses: a self-contained on-chip programming/boot-load master, and the bench driver for the core's tck/tms/tdi/tdo port.
- Accepts simple scan commands (TAP reset, IR scan, DR scan, idle clocks) over a valid/ready handshake and returns captured TDO bits.

---
 rtl/jtag_host_drv_if.sv | 27 ++
 rtl/jtag_host_drv.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jtag_host_drv_if.sv
// Command/response channel of the JTAG host driver.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; rsp_valid is a one-cycle pulse with no ready.
interface jtag_host_drv_if #(
    parameter int DIV_WIDTH = 8,
    parameter int MAX_LEN   = 32,
    parameter int LEN_WIDTH = 6
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic [MAX_LEN-1:0]   cmd_data;
    logic [DIV_WIDTH-1:0] tck_div;
    logic                 rsp_valid;
    logic [MAX_LEN-1:0]   rsp_data;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, tck_div,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, tck_div,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_host_drv.sv
// JTAG initiator: runs TAP reset / IR scan / DR scan / idle commands on tck/tms/tdi, captures tdo.
// Latency: Ntck * 2*(tck_div+1) clk from accept to rsp_valid.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are held by the sender.
module jtag_host_drv #(
    parameter int DIV_WIDTH = 8,
    parameter int MAX_LEN   = 32,
    parameter int LEN_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    jtag_host_drv_if.slave cmd,
    output logic           tck,
    output logic           tms,
    output logic           tdi,
    input  logic           tdo
);
    localparam int CNT_W = $clog2(MAX_LEN + 7);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t                 CNT_ONE = cnt_t'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;

    state_t               state;
    logic [1:0]           op_q;
    cnt_t                 lenm1_q;
    logic [MAX_LEN-1:0]   data_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    cnt_t                 bit_cnt;
    logic [MAX_LEN-1:0]   cap;
    logic                 busy_q;
    logic                 rsp_valid_q;
    logic [MAX_LEN-1:0]   rsp_data_q;

    cnt_t   len_m1_in;
    cnt_t   pre_last;
    state_t nxt_state;
    cnt_t   nxt_cnt;
    logic   seq_end;

    assign cmd.cmd_ready = (state == IDLE) && !rst;
    assign cmd.busy      = busy_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;

    // tms/tdi for one tck slot, identified by state and index within that state.
    function automatic logic [1:0] slot_pins(input state_t st, input cnt_t cnt, input logic [1:0] op,
                                             input cnt_t lm1, input logic [MAX_LEN-1:0] data);
        slot_pins = 2'b00;
        case (st)
            PRE: begin
                case (op)
                    OP_RESET: slot_pins = {cnt != cnt_t'(5), 1'b0};
                    OP_IR:    slot_pins = {cnt <  cnt_t'(2), 1'b0};
                    OP_DR:    slot_pins = {cnt == cnt_t'(0), 1'b0};
                    default:  slot_pins = 2'b00;
                endcase
            end
            SHIFT:   slot_pins = {cnt == lm1, |(data & (MAX_LEN'(1) << cnt))};
            POST:    slot_pins = {cnt == cnt_t'(0), 1'b0};
            default: slot_pins = 2'b00;
        endcase
    endfunction

    always_comb begin
        if (cmd.cmd_len == '0) begin
            len_m1_in = '0;
        end else if (int'(cmd.cmd_len) > MAX_LEN) begin
            len_m1_in = cnt_t'(MAX_LEN - 1);
        end else begin
            len_m1_in = cnt_t'(cmd.cmd_len) - CNT_ONE;
        end
    end

    always_comb begin
        case (op_q)
            OP_RESET: pre_last = cnt_t'(5);
            OP_IR:    pre_last = cnt_t'(3);
            OP_DR:    pre_last = cnt_t'(2);
            default:  pre_last = lenm1_q;
        endcase
    end

    // Reset and idle ops finish after PRE; scans go PRE -> SHIFT -> POST.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt + CNT_ONE;
        seq_end   = 1'b0;
        case (state)
            PRE: begin
                if (bit_cnt == pre_last) begin
                    nxt_cnt = '0;
                    if (op_q == OP_IR || op_q == OP_DR) nxt_state = SHIFT;
                    else                                 seq_end   = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == lenm1_q) begin
                    nxt_state = POST;
                    nxt_cnt   = '0;
                end
            end
            POST:    seq_end = (bit_cnt == CNT_ONE);
            default: seq_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            op_q        <= '0;
            lenm1_q     <= '0;
            data_q      <= '0;
            div_q       <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            cap         <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        state      <= PRE;
                        op_q       <= cmd.cmd_op;
                        lenm1_q    <= len_m1_in;
                        data_q     <= cmd.cmd_data;
                        div_q      <= cmd.tck_div;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        cap        <= '0;
                        busy_q     <= 1'b1;
                        tck        <= 1'b0;
                        {tms, tdi} <= slot_pins(PRE, '0, cmd.cmd_op, len_m1_in, cmd.cmd_data);
                    end
                end
                PRE, SHIFT, POST: begin
                    if (div_cnt != div_q) begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                        end else begin
                            // End of high phase: tdo is sampled here, then next slot's pins go out.
                            tck <= 1'b0;
                            if (state == SHIFT) cap <= cap | (MAX_LEN'(tdo) << bit_cnt);
                            if (seq_end) begin
                                state       <= DONE;
                                busy_q      <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cap;
                                tms         <= 1'b0;
                                tdi         <= 1'b0;
                            end else begin
                                state      <= nxt_state;
                                bit_cnt    <= nxt_cnt;
                                {tms, tdi} <= slot_pins(nxt_state, nxt_cnt, op_q, lenm1_q, data_q);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
